// File: rtl/autotest_result_logger.sv
// Autotest result logger: captures per-channel result bytes as {channel, data}
// records, packs them into a byte FIFO and writes them out as SD blocks.
module autotest_result_logger #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned FIFO_BYTES  = 1024,
  parameter int unsigned BLOCK_BYTES = 512,
  parameter logic [31:0] START_BLOCK = 32'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH*8-1:0]   uut_data,
  input  logic [NUM_CH-1:0]     uut_ctrl,
  input  logic                  flush,
  input  logic                  spi_busy,
  input  logic                  spi_err,
  input  logic                  spi_byte_req,
  output logic                  spi_w_block,
  output logic                  spi_w_byte,
  output logic [7:0]            spi_data_in,
  output logic [31:0]           spi_block_addr,
  output logic [31:0]           blocks_written,
  output logic                  overflow,
  output logic                  error
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_BYTES);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned BLK_W = $clog2(BLOCK_BYTES) + 1;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] SEND = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
  localparam logic [2:0] ERR  = 3'd4;

  // capture side
  logic [NUM_CH-1:0] ctrl_q;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] hold_valid;
  logic [7:0]        hold_data [NUM_CH];

  // drainer
  logic              drn_phase;
  logic [CH_W-1:0]   drn_ch;
  logic [CH_W-1:0]   rr_q;
  logic [CH_W-1:0]   rr_next;
  logic [CH_W:0]     rr_inc;
  logic [CH_W:0]     scan_idx;
  logic              pick_found;
  logic [CH_W-1:0]   pick_ch;
  logic              push;
  logic [7:0]        push_byte;
  logic              drain_done;

  // fifo
  logic [7:0]        mem [FIFO_BYTES];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  fifo_free;

  // writer
  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [BLK_W-1:0]  sent_q;
  logic [BLK_W-1:0]  snap_q;
  logic [BLK_W-1:0]  snap_d;
  logic [CNT_W-1:0]  snap_full;
  logic              flush_pend;
  logic              byte_go;
  logic              pop;
  logic              enter_req;
  logic              finish;

  assign rise      = uut_ctrl & ~ctrl_q;
  assign fifo_free = CNT_W'(FIFO_BYTES) - count;

  // Round-robin search for the next pending holding register
  always_comb begin
    pick_found = 1'b0;
    pick_ch    = '0;
    scan_idx   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      scan_idx = {1'b0, rr_q} + (CH_W+1)'(i);
      if (scan_idx >= (CH_W+1)'(NUM_CH)) scan_idx = scan_idx - (CH_W+1)'(NUM_CH);
      if (!pick_found && hold_valid[scan_idx[CH_W-1:0]]) begin
        pick_found = 1'b1;
        pick_ch    = scan_idx[CH_W-1:0];
      end
    end
  end

  // Drain byte selection: index byte only when the whole record fits
  always_comb begin
    push       = 1'b0;
    push_byte  = '0;
    drain_done = 1'b0;
    rr_inc     = {1'b0, drn_ch} + (CH_W+1)'(1);
    rr_next    = (rr_inc >= (CH_W+1)'(NUM_CH)) ? '0 : rr_inc[CH_W-1:0];
    if (!drn_phase) begin
      if (pick_found && fifo_free >= CNT_W'(2)) begin
        push      = 1'b1;
        push_byte = 8'(pick_ch);
      end
    end else begin
      push       = 1'b1;
      push_byte  = hold_data[drn_ch];
      drain_done = 1'b1;
    end
  end

  // Edge detect and per-channel one-deep holding registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q     <= '0;
      hold_valid <= '0;
      overflow   <= 1'b0;
      for (int unsigned k = 0; k < NUM_CH; k++) hold_data[k] <= '0;
    end else begin
      ctrl_q <= uut_ctrl;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (drain_done && drn_ch == CH_W'(k)) hold_valid[k] <= 1'b0;
        if (rise[k]) begin
          if (hold_valid[k]) begin
            overflow <= 1'b1;
          end else begin
            hold_valid[k] <= 1'b1;
            hold_data[k]  <= uut_data[8*k +: 8];
          end
        end
      end
    end
  end

  // Drainer phase and round-robin pointer (back to ch0 when nothing pending)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drn_phase <= 1'b0;
      drn_ch    <= '0;
      rr_q      <= '0;
    end else if (!drn_phase) begin
      if (push) begin
        drn_phase <= 1'b1;
        drn_ch    <= pick_ch;
      end else if (hold_valid == '0) begin
        rr_q <= '0;
      end
    end else begin
      drn_phase <= 1'b0;
      rr_q      <= rr_next;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_byte;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Snapshot includes a data byte landing this cycle so records stay whole
  always_comb begin
    snap_full = count + CNT_W'(drn_phase);
    snap_d    = (snap_full >= CNT_W'(BLOCK_BYTES)) ? BLK_W'(BLOCK_BYTES) : BLK_W'(snap_full);
  end

  // Writer next-state logic
  always_comb begin
    state_d   = state_q;
    byte_go   = 1'b0;
    pop       = 1'b0;
    enter_req = 1'b0;
    finish    = 1'b0;
    case (state_q)
      IDLE: begin
        if (count >= CNT_W'(BLOCK_BYTES) || (flush_pend && count != '0)) begin
          state_d   = REQ;
          enter_req = 1'b1;
        end
      end
      REQ: begin
        if (spi_busy) state_d = SEND;
      end
      SEND: begin
        if (spi_byte_req) begin
          byte_go = 1'b1;
          pop     = (sent_q < snap_q);
          if (sent_q == BLK_W'(BLOCK_BYTES - 1)) state_d = DONE;
        end
      end
      DONE: begin
        if (!spi_busy) begin
          state_d = IDLE;
          finish  = 1'b1;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
    if (spi_err) begin
      state_d   = ERR;
      byte_go   = 1'b0;
      pop       = 1'b0;
      enter_req = 1'b0;
      finish    = 1'b0;
    end
  end

  // Writer state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Writer datapath and registered SD-side outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sent_q         <= '0;
      snap_q         <= '0;
      flush_pend     <= 1'b0;
      spi_w_block    <= 1'b0;
      spi_w_byte     <= 1'b0;
      spi_data_in    <= '0;
      spi_block_addr <= START_BLOCK;
      blocks_written <= '0;
      error          <= 1'b0;
    end else begin
      spi_w_block <= (state_d == REQ) || (state_d == SEND);
      spi_w_byte  <= byte_go;
      if (byte_go) begin
        spi_data_in <= pop ? mem[rd_ptr] : 8'hFF;
        sent_q      <= sent_q + BLK_W'(1);
      end
      if (enter_req) begin
        sent_q <= '0;
        snap_q <= snap_d;
      end
      if (finish) begin
        spi_block_addr <= spi_block_addr + 32'd1;
        blocks_written <= blocks_written + 32'd1;
      end
      if (finish)                     flush_pend <= 1'b0;
      else if (flush && count != '0)  flush_pend <= 1'b1;
      if (spi_err) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_autotest_result_logger.sv
// Randomized self-checking bench for autotest_result_logger with an SD host model.
module tb_autotest_result_logger;

  localparam int unsigned NUM_CH      = 2;
  localparam int unsigned FIFO_BYTES  = 1024;
  localparam int unsigned BLOCK_BYTES = 512;
  localparam logic [31:0] START_BLOCK = 32'd100;

  logic                clk;
  logic                rst;
  logic [NUM_CH*8-1:0] uut_data;
  logic [NUM_CH-1:0]   uut_ctrl;
  logic                flush;
  logic                spi_busy;
  logic                spi_err;
  logic                spi_byte_req;
  logic                spi_w_block;
  logic                spi_w_byte;
  logic [7:0]          spi_data_in;
  logic [31:0]         spi_block_addr;
  logic [31:0]         blocks_written;
  logic                overflow;
  logic                error;

  autotest_result_logger #(
    .NUM_CH(NUM_CH), .FIFO_BYTES(FIFO_BYTES),
    .BLOCK_BYTES(BLOCK_BYTES), .START_BLOCK(START_BLOCK)
  ) dut (
    .clk(clk), .rst(rst), .uut_data(uut_data), .uut_ctrl(uut_ctrl),
    .flush(flush), .spi_busy(spi_busy), .spi_err(spi_err),
    .spi_byte_req(spi_byte_req), .spi_w_block(spi_w_block),
    .spi_w_byte(spi_w_byte), .spi_data_in(spi_data_in),
    .spi_block_addr(spi_block_addr), .blocks_written(blocks_written),
    .overflow(overflow), .error(error)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q [$];
  logic [7:0]  rx [$];
  int          blk_cnt = 0;
  logic [31:0] blk_since_rst = 0;
  int          strobe_cnt = 0;
  int          last_ndata = 0;
  bit          host_en = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Walk a finished block: records pair up from the start, 8'hFF in an index slot begins padding
  task automatic parse_block();
    int nd, bad;
    bit pad;
    logic [15:0] pr;
    nd = 0; bad = 0; pad = 1'b0;
    for (int i = 0; i < int'(BLOCK_BYTES); i += 2) begin
      pr = {rx[i], rx[i+1]};
      if (!pad && rx[i] == 8'hFF) pad = 1'b1;
      if (pad) begin
        if (pr != 16'hFFFF) bad++;
      end else if (exp_q.size() == 0) begin
        check("unexpected_rec", 32'(pr), 32'h0000FFFF);
      end else begin
        check("rec", 32'(pr), 32'(exp_q.pop_front()));
        nd += 2;
      end
    end
    check("pad", 32'(bad), 32'd0);
    last_ndata = nd;
  endtask

  // Byte monitor: assembles blocks from strobes
  always @(negedge clk) begin
    if (!rst) begin
      rx.delete();
      blk_since_rst = 0;
    end else if (spi_w_byte) begin
      strobe_cnt++;
      rx.push_back(spi_data_in);
      if (rx.size() == BLOCK_BYTES) begin
        check("blk_addr", spi_block_addr, START_BLOCK + blk_since_rst);
        check("blk_count", blocks_written, blk_since_rst);
        parse_block();
        rx.delete();
        blk_since_rst = blk_since_rst + 32'd1;
        blk_cnt++;
      end
    end
  end

  // SD host model
  initial begin
    spi_busy = 1'b0;
    spi_byte_req = 1'b0;
    forever begin
      @(negedge clk);
      if (host_en && rst && spi_w_block && !spi_busy) begin
        spi_busy = 1'b1;
        repeat (2) @(negedge clk);
        for (int b = 0; b < int'(BLOCK_BYTES) && spi_w_block; b++) begin
          spi_byte_req = 1'b1;
          @(negedge clk);
          spi_byte_req = 1'b0;
          @(negedge clk);
        end
        spi_byte_req = 1'b0;
        for (int t = 0; t < 20 && spi_w_block; t++) @(negedge clk);
        repeat (2) @(negedge clk);
        spi_busy = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic rec(input int ch, input logic [7:0] d, input bit keep);
    uut_data[ch*8 +: 8] = d;
    uut_ctrl[ch] = 1'b1;
    if (keep) exp_q.push_back({8'(ch), d});
    @(negedge clk);
    uut_ctrl[ch] = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic flush_drain();
    repeat (6) @(negedge clk);
    for (int a = 0; a < 4 && exp_q.size() != 0; a++) begin
      pulse_flush();
      for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(negedge clk);
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_blocks(input int target);
    for (int t = 0; t < 6000 && blk_cnt < target; t++) @(negedge clk);
    check("blk_wait", 32'(blk_cnt >= target), 32'd1);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_wblock"}, 32'(spi_w_block), 32'd0);
    check({tag, "_wbyte"}, 32'(spi_w_byte), 32'd0);
    check({tag, "_data"}, 32'(spi_data_in), 32'd0);
    check({tag, "_addr"}, spi_block_addr, START_BLOCK);
    check({tag, "_blocks"}, blocks_written, 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
    check({tag, "_err"}, 32'(error), 32'd0);
  endtask

  initial begin
    int          base, s0, ch;
    logic [7:0]  d0, d1;
    rst = 1'b0; uut_data = '0; uut_ctrl = '0; flush = 1'b0; spi_err = 1'b0;
    host_en = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outs("rst");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // one record on ch1, then flush: 01 A5 + padding
    rec(1, 8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    flush_drain();
    check("flush_ndata", 32'(last_ndata), 32'd2);
    check("flush_blocks", blocks_written, 32'd1);
    check("flush_addr", spi_block_addr, START_BLOCK + 32'd1);

    // same-cycle edges on ch0 and ch1
    d0 = 8'($urandom); d1 = 8'($urandom);
    uut_data = {d1, d0};
    uut_ctrl = 2'b11;
    exp_q.push_back({8'd0, d0});
    exp_q.push_back({8'd1, d1});
    @(negedge clk);
    uut_ctrl = 2'b00;
    @(negedge clk);
    flush_drain();
    check("simul_ndata", 32'(last_ndata), 32'd4);

    // 256 alternating records fill exactly one block without flush
    base = blk_cnt;
    for (int n = 0; n < 256; n++) rec(n % 2, 8'($urandom), 1'b1);
    wait_blocks(base + 1);
    repeat (10) @(negedge clk);
    check("alt_ndata", 32'(last_ndata), 32'(BLOCK_BYTES));
    check("alt_left", 32'(exp_q.size()), 32'd0);
    check("alt_blocks", blocks_written, 32'd3);

    // randomized records with occasional flushes
    for (int n = 0; n < 60; n++) begin
      ch = int'($urandom_range(0, NUM_CH - 1));
      rec(ch, 8'($urandom), 1'b1);
      repeat ($urandom_range(1, 4)) @(negedge clk);
      if ($urandom_range(0, 9) == 0) pulse_flush();
    end
    flush_drain();
    check("rand_blocks", blocks_written, blk_since_rst);
    check("rand_addr", spi_block_addr, START_BLOCK + blk_since_rst);

    // asynchronous reset in the middle of a block send
    for (int n = 0; n < 20; n++) rec(n % 2, 8'($urandom), 1'b1);
    repeat (4) @(negedge clk);
    pulse_flush();
    s0 = strobe_cnt;
    for (int t = 0; t < 3000 && strobe_cnt < s0 + 5; t++) @(negedge clk);
    check("mid_send_reached", 32'(strobe_cnt >= s0 + 5), 32'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outs("async_rst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    s0 = strobe_cnt;
    repeat (100) @(negedge clk);
    check("no_strobe_after_rst", 32'(strobe_cnt), 32'(s0));

    // overflow with the FIFO full and the writer stalled in REQ
    host_en = 1'b0;
    for (int n = 0; n < int'(FIFO_BYTES / 2); n++) rec(n % 2, 8'($urandom), 1'b1);
    repeat (6) @(negedge clk);
    check("ovf_before", 32'(overflow), 32'd0);
    rec(0, 8'h3C, 1'b1);
    rec(0, 8'hC3, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    base = blk_cnt;
    host_en = 1'b1;
    wait_blocks(base + 2);
    flush_drain();
    check("ovf_last_ndata", 32'(last_ndata), 32'd2);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // SD error during SEND
    for (int n = 0; n < 10; n++) rec(n % 2, 8'($urandom), 1'b1);
    repeat (4) @(negedge clk);
    pulse_flush();
    s0 = strobe_cnt;
    for (int t = 0; t < 3000 && strobe_cnt < s0 + 6; t++) @(negedge clk);
    check("err_send_reached", 32'(strobe_cnt >= s0 + 6), 32'd1);
    spi_err = 1'b1;
    @(negedge clk);
    spi_err = 1'b0;
    check("err_flag", 32'(error), 32'd1);
    check("err_wblock", 32'(spi_w_block), 32'd0);
    s0 = strobe_cnt;
    for (int n = 0; n < 10; n++) rec(n % 2, 8'($urandom), 1'b0);
    pulse_flush();
    repeat (100) @(negedge clk);
    check("err_hold_wblock", 32'(spi_w_block), 32'd0);
    check("err_hold_flag", 32'(error), 32'd1);
    check("err_no_strobe", 32'(strobe_cnt), 32'(s0));
    rst = 1'b0;
    #1 check_reset_outs("err_rst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/autotest_result_logger.md
AUTOTEST_RESULT_LOGGER -- requirements
Module: autotest_result_logger

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, meaning the number of UUT result channels (1..16).
REQ-002 The block SHALL have parameter FIFO_BYTES, default 1024, meaning the byte FIFO depth (power of two, at least 2*BLOCK_BYTES).
REQ-003 The block SHALL have parameter BLOCK_BYTES, default 512, meaning the bytes per SD block.
REQ-004 The block SHALL have parameter START_BLOCK, default 32'd0, meaning the first SD block address.
REQ-005 The block SHALL have port clk, input, width 1, meaning the single clock for all logic.
REQ-006 The block SHALL have port rst, input, width 1, meaning the reset, which is asynchronous and active-low.
REQ-007 The block SHALL have port uut_data, input, width NUM_CH*8, meaning the result byte of each channel; channel k occupies bits [8k+7:8k].
REQ-008 The block SHALL have port uut_ctrl, input, width NUM_CH, meaning the result-valid level of each channel.
REQ-009 The block SHALL have port flush, input, width 1, meaning a pulse that forces the partial block to be written.
REQ-010 The block SHALL have port spi_busy, input, width 1, meaning the SD host is busy.
REQ-011 The block SHALL have port spi_err, input, width 1, meaning the SD host error flag.
REQ-012 The block SHALL have port spi_byte_req, input, width 1, meaning a one-cycle pulse by which the host requests the next write byte.
REQ-013 The block SHALL have port spi_w_block, output, width 1, meaning the block-write request.
REQ-014 The block SHALL have port spi_w_byte, output, width 1, meaning the byte-valid strobe.
REQ-015 The block SHALL have port spi_data_in, output, width 8, meaning the write byte.
REQ-016 The block SHALL have port spi_block_addr, output, width 32, meaning the target block address.
REQ-017 The block SHALL have port blocks_written, output, width 32, meaning the count of completed blocks.
REQ-018 The block SHALL have port overflow, output, width 1, meaning a sticky flag for a dropped record.
REQ-019 The block SHALL have port error, output, width 1, meaning a sticky flag for an SD error.

Function
REQ-020 Each channel SHALL register uut_ctrl and detect its rising edge; each edge SHALL create one record {8'(k), uut_data[k]} that is latched in the same cycle as the edge.
REQ-021 Pending records SHALL sit in a one-deep holding register per channel and be drained round-robin at one record per 2 cycles (one byte per cycle), channel index byte first, then data byte.
REQ-022 A new edge on a channel whose holding register is still full SHALL drop the new record and set overflow.
REQ-023 A record SHALL be drained only when the FIFO has at least 2 free bytes, so a record is never split; while the holding register waits, it keeps its record.
REQ-024 The writer FSM SHALL have states IDLE, REQ, SEND, DONE, ERR.
REQ-025 IDLE SHALL move to REQ when the FIFO count is at least BLOCK_BYTES, or when flush is pending and the FIFO count is nonzero.
REQ-026 A flush that arrives with an empty FIFO SHALL be discarded.
REQ-027 In REQ, spi_w_block SHALL be asserted with spi_block_addr stable, and the FSM SHALL move to SEND on the first cycle spi_busy=1.
REQ-028 In SEND, each spi_byte_req SHALL cause spi_data_in and a one-cycle spi_w_byte on the next cycle.
REQ-029 In SEND, the byte source SHALL be the FIFO head while sent bytes are below the latched snapshot length, and 8'hFF padding otherwise.
REQ-030 After BLOCK_BYTES bytes the FSM SHALL drop spi_w_block and enter DONE.
REQ-031 In DONE, on spi_busy=0 the block SHALL increment spi_block_addr (wrapping at 2^32), increment blocks_written, clear the pending flush and return to IDLE.
REQ-032 An spi_err=1 in any state SHALL set error and force ERR, which the block leaves only through reset; in ERR, spi_w_block=0 and spi_w_byte=0, and capture continues until the FIFO is full.
REQ-033 Records that arrive during SEND SHALL be accepted; the snapshot length is fixed at REQ entry.

Reset
REQ-034 Asserting rst low SHALL asynchronously clear the FIFO, holding registers, edge registers, flush pending, overflow, error, blocks_written, spi_w_block, spi_w_byte and spi_data_in, set spi_block_addr=START_BLOCK, and enter IDLE.
REQ-035 Reset released mid-SEND SHALL cause no further byte strobes.

Verification
REQ-036 The bench SHALL cover: NUM_CH=2, one uut_ctrl edge on ch1 with data 8'hA5, then flush -> one block whose bytes are 01,A5, followed by 510 bytes of FF; blocks_written=1; spi_block_addr=START_BLOCK+1.
REQ-037 The bench SHALL cover: 256 alternating ch0/ch1 records -> one block written with no flush, and the bytes in arrival order.
REQ-038 The bench SHALL cover: ch0 and ch1 edges in the same cycle -> ch0 record first, then ch1; both retained.
REQ-039 The bench SHALL cover: two ch0 edges 1 cycle apart while the FIFO is full -> overflow=1 and the second record absent.
REQ-040 The bench SHALL cover: spi_err pulse during SEND -> error=1, spi_w_block=0 next cycle, and the state held until rst low.
REQ-041 The bench SHALL cover: rst low during SEND -> all outputs at reset values immediately, without waiting for a clock edge.
